// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - hazard / branch / input-wait control for a fetch + two-stage decode pipeline
//
// Purpose: drives the load enables and bubble (flush) strobes of the PC/fetch
// stage and the two decode registers, resolving input waits, taken branches and
// read-after-write hazards against the stage-two instruction.
//
// Optional feature: define PIPE_CTRL_STATS_EN to build the saturating
// stall/flush statistics counters; otherwise both counters read constant zero.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   rdA, rdB, rdA_use, rdB_use  stage-one source registers and their use flags
//   ex_wren, ex_writeAd       stage-two register write enable / address
//   ex_input                  stage-two instruction consumes external input
//   ex_pc_load, ex_cond_true  stage-two branch / branch condition true
//   in_valid                  external input data available
//   stats_clr                 synchronous clear of the statistics counters
//   fetch_en, dec1_en, dec2_en  stage load enables
//   dec1_flush, dec2_flush    load a bubble into decode register one / two
//   pc_stall, in_ack          PC frozen / one-cycle input consume strobe
//   state                     FSM state (RUN=0, FLUSH=1, WAIT_IN=2)
//   stall_cnt, flush_cnt      statistics counters

module pipeline_control_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  rdA,
    input  logic [2:0]  rdB,
    input  logic        rdA_use,
    input  logic        rdB_use,
    input  logic        ex_wren,
    input  logic [2:0]  ex_writeAd,
    input  logic        ex_input,
    input  logic        ex_pc_load,
    input  logic        ex_cond_true,
    input  logic        in_valid,
    input  logic        stats_clr,
    output logic        fetch_en,
    output logic        dec1_en,
    output logic        dec2_en,
    output logic        dec1_flush,
    output logic        dec2_flush,
    output logic        pc_stall,
    output logic        in_ack,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_WAIT_IN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic in_wait, taken, haz;

    assign in_wait = ex_input & ~in_valid;
    assign taken   = ex_pc_load & ex_cond_true;
    assign haz     = ex_wren & ((rdA_use & (rdA == ex_writeAd)) |
                                (rdB_use & (rdB == ex_writeAd)));

    assign state = state_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN: begin
                if (in_wait) begin
                    state_d = ST_WAIT_IN;
                end else if (taken) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH:   state_d = ST_RUN;
            ST_WAIT_IN: state_d = in_valid ? ST_RUN : ST_WAIT_IN;
            default:    state_d = ST_RUN;
        endcase
    end

    // Outputs also decode RST so the reset values appear without waiting for a clock.
    always_comb begin
        fetch_en   = 1'b0;
        dec1_en    = 1'b0;
        dec2_en    = 1'b0;
        dec1_flush = 1'b0;
        dec2_flush = 1'b0;
        pc_stall   = 1'b0;
        in_ack     = 1'b0;
        if (RST) begin
            pc_stall = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (in_wait) begin
                        pc_stall = 1'b1;
                    end else if (taken) begin
                        fetch_en   = 1'b1;
                        dec1_en    = 1'b1;
                        dec2_en    = 1'b1;
                        dec1_flush = 1'b1;
                        dec2_flush = 1'b1;
                    end else if (haz) begin
                        // Hold fetch and stage one; the producer moves on and a
                        // single bubble is slotted in behind it.
                        pc_stall   = 1'b1;
                        dec2_en    = 1'b1;
                        dec2_flush = 1'b1;
                    end else begin
                        fetch_en = 1'b1;
                        dec1_en  = 1'b1;
                        dec2_en  = 1'b1;
                        in_ack   = ex_input;
                    end
                end
                ST_FLUSH: begin
                    // Second penalty cycle: only the wrong-path fetch is squashed.
                    fetch_en   = 1'b1;
                    dec1_en    = 1'b1;
                    dec2_en    = 1'b1;
                    dec1_flush = 1'b1;
                end
                ST_WAIT_IN: begin
                    if (in_valid) begin
                        fetch_en = 1'b1;
                        dec1_en  = 1'b1;
                        dec2_en  = 1'b1;
                        in_ack   = 1'b1;
                    end else begin
                        pc_stall = 1'b1;
                    end
                end
                default: begin
                    pc_stall = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        flush_inc;

    assign flush_inc = (state_q == ST_RUN) & ~in_wait & taken;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else if (stats_clr) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (pc_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush_inc && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - randomized self-checking bench for pipeline_control_unit

module tb_pipeline_control_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  rdA, rdB, ex_writeAd;
    logic        rdA_use, rdB_use, ex_wren, ex_input, ex_pc_load, ex_cond_true;
    logic        in_valid, stats_clr;
    logic        fetch_en, dec1_en, dec2_en, dec1_flush, dec2_flush, pc_stall, in_ack;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: mode 0 = running, 1 = second branch-penalty cycle, 2 = waiting for input
    int mode   = 0;
    int mstall = 0;
    int mflush = 0;

    pipeline_control_unit dut (
        .CLK(CLK), .RST(RST),
        .rdA(rdA), .rdB(rdB), .rdA_use(rdA_use), .rdB_use(rdB_use),
        .ex_wren(ex_wren), .ex_writeAd(ex_writeAd),
        .ex_input(ex_input), .ex_pc_load(ex_pc_load), .ex_cond_true(ex_cond_true),
        .in_valid(in_valid), .stats_clr(stats_clr),
        .fetch_en(fetch_en), .dec1_en(dec1_en), .dec2_en(dec2_en),
        .dec1_flush(dec1_flush), .dec2_flush(dec2_flush),
        .pc_stall(pc_stall), .in_ack(in_ack), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit f_wait();
        return ex_input && !in_valid;
    endfunction

    function automatic bit f_taken();
        return ex_pc_load && ex_cond_true;
    endfunction

    function automatic bit f_haz();
        return ex_wren && ((rdA_use && rdA == ex_writeAd) || (rdB_use && rdB == ex_writeAd));
    endfunction

    // {fetch_en, dec1_en, dec2_en, dec1_flush, dec2_flush, pc_stall, in_ack}
    function automatic logic [6:0] model_out();
        if (RST) return 7'b000_00_1_0;
        if (mode == 1) return 7'b111_10_0_0;
        if (mode == 2) return in_valid ? 7'b111_00_0_1 : 7'b000_00_1_0;
        if (f_wait())  return 7'b000_00_1_0;
        if (f_taken()) return 7'b111_11_0_0;
        if (f_haz())   return 7'b001_01_1_0;
        return {6'b111_00_0, ex_input};
    endfunction

    task automatic set_idle();
        rdA = 3'd0; rdB = 3'd0; rdA_use = 1'b0; rdB_use = 1'b0;
        ex_wren = 1'b0; ex_writeAd = 3'd0; ex_input = 1'b0;
        ex_pc_load = 1'b0; ex_cond_true = 1'b0; in_valid = 1'b0; stats_clr = 1'b0;
    endtask

    // Called in the low clock phase with inputs settled; checks, then advances one edge.
    task automatic tick();
        logic [6:0] e;
        bit         w, t;
        #1;
        e = model_out();
        check("outputs", {25'd0, fetch_en, dec1_en, dec2_en, dec1_flush, dec2_flush, pc_stall, in_ack},
              {25'd0, e});
        check("state", {30'd0, state}, RST ? 32'd0 : mode);
        check("stall_cnt", {16'd0, stall_cnt}, RST ? 32'd0 : mstall);
        check("flush_cnt", {16'd0, flush_cnt}, RST ? 32'd0 : mflush);
        check("flush_gated", {30'd0, dec1_flush & ~dec1_en, dec2_flush & ~dec2_en}, 32'd0);
        w = f_wait();
        t = f_taken();
        @(posedge CLK);
        if (RST) begin
            mode = 0; mstall = 0; mflush = 0;
        end else begin
`ifdef PIPE_CTRL_STATS_EN
            if (stats_clr) begin
                mstall = 0; mflush = 0;
            end else begin
                if (e[1] && mstall < 65535) mstall++;
                if (mode == 0 && !w && t && mflush < 65535) mflush++;
            end
`endif
            case (mode)
                0:       mode = w ? 2 : (t ? 1 : 0);
                1:       mode = 0;
                default: mode = in_valid ? 0 : 2;
            endcase
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        set_idle();
        @(negedge CLK);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Read-after-write hazard on rdA
        ex_wren = 1'b1; ex_writeAd = 3'd3; rdA = 3'd3; rdA_use = 1'b1;
        tick();
        set_idle();
        tick();

        // Taken branch: two-cycle penalty
        ex_pc_load = 1'b1; ex_cond_true = 1'b1;
        tick();
        set_idle();
        tick();
        tick();

        // Input wait for four cycles, then a single acknowledge
        ex_input = 1'b1;
        repeat (4) tick();
        in_valid = 1'b1;
        tick();
        set_idle();
        tick();

        // Wait, taken and hazard together: wait wins
        ex_input = 1'b1; ex_pc_load = 1'b1; ex_cond_true = 1'b1;
        ex_wren = 1'b1; ex_writeAd = 3'd5; rdB = 3'd5; rdB_use = 1'b1;
        tick();
        tick();
        in_valid = 1'b1;
        tick();
        set_idle();
        tick();

        // Reset in the middle of an input wait
        ex_input = 1'b1;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        set_idle();
        tick();

        // Reset during the branch-penalty cycle
        ex_pc_load = 1'b1; ex_cond_true = 1'b1;
        tick();
        set_idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdA          = 3'($urandom_range(0, 7));
            rdB          = 3'($urandom_range(0, 7));
            ex_writeAd   = 3'($urandom_range(0, 7));
            rdA_use      = 1'($urandom_range(0, 1));
            rdB_use      = 1'($urandom_range(0, 1));
            ex_input     = ($urandom_range(0, 3) == 0);
            ex_wren      = ex_input ? 1'b0 : 1'($urandom_range(0, 1));
            ex_pc_load   = ex_input ? 1'b0 : ($urandom_range(0, 3) == 0);
            ex_cond_true = 1'($urandom_range(0, 1));
            in_valid     = 1'($urandom_range(0, 1));
            stats_clr    = ($urandom_range(0, 31) == 0);
            RST          = ($urandom_range(0, 199) == 0);
            if (mode == 2) ex_input = 1'b1;
            tick();
        end
        RST = 1'b0;
        set_idle();
        tick();

`ifdef PIPE_CTRL_STATS_EN
        // Saturation of the stall counter, then clear while still stalling
        ex_input = 1'b1;
        repeat (70000) tick();
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        set_idle();
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_control_unit.md
PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port rdA, rdB  input  3 each  source register addresses of instruction in decode stage one.
REQ-004 SHALL have port rdA_use, rdB_use  input  1 each  corresponding source actually read.
REQ-005 SHALL have port ex_wren, ex_writeAd  input  1/3  register write enable/address held in decode stage two register.
REQ-006 SHALL have port ex_input, ex_pc_load, ex_cond_true  input  1 each  stage-two instruction needs external input / is branch / branch condition evaluated true.
REQ-007 SHALL have port in_valid  input  1  external input data available.
REQ-008 SHALL have port stats_clr  input  1  synchronous clear of statistics counters.
REQ-009 SHALL have ports fetch_en, dec1_en, dec2_en  output  1 each  load enables of PC/fetch, decode register one, decode register two.
REQ-010 SHALL have ports dec1_flush, dec2_flush  output  1 each  load a bubble (all control fields zero) into that register.
REQ-011 SHALL have ports pc_stall, in_ack  output  1 each  PC frozen / one-cycle input consume strobe.
REQ-012 SHALL have port state  output  2  FSM state: RUN=0, FLUSH=1, WAIT_IN=2; 3 unused.
REQ-013 SHALL have ports stall_cnt, flush_cnt  output  16 each  statistics counters.

Function
REQ-014 SHALL define wait = ex_input & ~in_valid; taken = ex_pc_load & ex_cond_true; haz = ex_wren & ((rdA_use & rdA==ex_writeAd) | (rdB_use & rdB==ex_writeAd)).
REQ-015 SHALL in RUN apply priority wait > taken > haz > normal; outputs combinational from state and these terms.
REQ-016 RUN normal: fetch_en=dec1_en=dec2_en=1, flushes=0, pc_stall=0, in_ack=ex_input (input consumed same cycle when in_valid=1); next RUN.
REQ-017 RUN wait: all enables 0, pc_stall=1, in_ack=0; next WAIT_IN.
REQ-018 RUN taken: enables 1, dec1_flush=dec2_flush=1; next FLUSH.
REQ-019 RUN haz: fetch_en=dec1_en=0, pc_stall=1, dec2_en=1, dec2_flush=1 (single bubble); next RUN.
REQ-020 FLUSH: lasts exactly one cycle, enables 1, dec1_flush=1, dec2_flush=0; taken/haz ignored; next RUN; total branch penalty 2 cycles.
REQ-021 WAIT_IN: while in_valid=0 outputs as REQ-017, stay; cycle in_valid=1 -> in_ack=1, enables 1, pc_stall=0, next RUN.
REQ-022 in_ack SHALL never be high for more than one cycle per ex_input instruction.
REQ-023 dec1_flush/dec2_flush SHALL never be high while the matching enable is 0.
REQ-024 State encoding 3 SHALL never be reached; if forced, next state RUN.

Reset
REQ-025 While RST=1: state=RUN, fetch_en=dec1_en=dec2_en=0, flushes=0, in_ack=0, pc_stall=1, stall_cnt=flush_cnt=0, effective immediately (asynchronous).
REQ-026 RST asserted in WAIT_IN or FLUSH SHALL abandon the operation with no in_ack/flush issued; first cycle after release is RUN.

Configuration
REQ-027 With PIPE_CTRL_STATS_EN defined: stall_cnt increments each cycle pc_stall=1, flush_cnt increments on each RUN->FLUSH transition; both saturate at 0xFFFF; stats_clr zeros both (clear wins over increment).
REQ-028 Without PIPE_CTRL_STATS_EN: no counter flops; stall_cnt=flush_cnt=0 constant; stats_clr ignored; all other behaviour identical.

Verification
REQ-029 RST pulse mid-WAIT_IN -> state=0 and pc_stall=1 immediately, no in_ack, counters 0.
REQ-030 ex_wren=1, ex_writeAd=3, rdA=3, rdA_use=1 -> one cycle fetch_en=0, dec2_flush=1, stall_cnt=1; next cycle normal.
REQ-031 taken=1 in RUN -> cycle0 dec1_flush=dec2_flush=1, cycle1 state=1 dec1_flush=1, cycle2 state=0; flush_cnt=1.
REQ-032 ex_input=1, in_valid low 4 cycles then high -> 4 stall cycles with pc_stall=1, then single in_ack, stall_cnt=4.
REQ-033 wait, taken and haz all true in RUN -> WAIT_IN entered, no flush, no branch counted.
REQ-034 Stats build: force 70000 stall cycles -> stall_cnt=0xFFFF; stats_clr with concurrent stall -> 0.
